ddr3_int_traffic_driver: RTL and testbench
==========================================

Name: ddr3_int_traffic_driver

Overview:
Example-design traffic generator that drives the DDR3 controller local (Avalon-style) interface from inside the example top. After controller initialisation it writes a deterministic pattern to a block of addresses, reads it back, compares it, and repeats for a fixed number of passes. It produces the pass/fail and completion signals (pnf, pnf_per_byte, test_complete, test_status) that the system testbench polls to end simulation.

Parameters:
LOCAL_DATA_BITS  128  local data width; must be a multiple of 64
ADDR_BITS  24  local address width
BASE_ADDR  0  first local word address tested
NUM_WORDS  16  words written/read per pass (1..2^16)
NUM_PASSES  4  write/read passes before completion (1..255)

Ports:
clk  in  1  controller half-rate local clock
reset  in  1  asynchronous reset, active-high
local_init_done  in  1  controller calibration/init complete
local_ready  in  1  controller accepts request this cycle
local_write_req  out  1  write request
local_read_req  out  1  read request
local_burstbegin  out  1  equals (local_write_req | local_read_req)
local_address  out  ADDR_BITS  word address
local_size  out  1  constant 1 (single-beat)
local_be  out  LOCAL_DATA_BITS/8  constant all ones
local_wdata  out  LOCAL_DATA_BITS  write data
local_rdata  in  LOCAL_DATA_BITS  read data
local_rdata_valid  in  1  read data valid
pnf  out  1  sticky pass-not-fail, all bytes
pnf_per_byte  out  LOCAL_DATA_BITS/8  sticky per-byte pass
test_complete  out  1  high while in DONE
test_status  out  8  debug status

Behaviour:
- Reset (async, active-high): state IDLE, all request outputs 0, address BASE_ADDR, counters 0, pnf=1, pnf_per_byte all 1, test_complete=0, test_status=0.
- Pattern: w = {pass[7:0], idx[23:0]} (idx zero-extended/truncated to 24 bits); 32-bit lane k of data = w for even k, ~w for odd k. Address = BASE_ADDR + idx, mod 2^ADDR_BITS.
- Handshake: a request is accepted in any cycle where req=1 and local_ready=1; req, address and wdata are held stable until accepted; on acceptance idx increments and the next request is presented the following cycle (back-to-back allowed).
- States:
  IDLE: wait for local_init_done=1, then go to WRITE with idx=0, pass=0.
  WRITE: issue NUM_WORDS writes; after the last accept go to READ with idx=0 and req low for exactly one cycle.
  READ: issue NUM_WORDS reads; rx counter runs independently; after the last accept go to WAIT_RD.
  WAIT_RD: wait until rx count == NUM_WORDS; then, if pass == NUM_PASSES-1, go to DONE, else pass++ and go to WRITE.
  DONE: test_complete=1; terminal until reset.
- Compare: read data returns in order. On each local_rdata_valid in READ/WAIT_RD, compare against the pattern for (pass, rx_idx). Any mismatching byte clears its pnf_per_byte bit on the next clock; pnf = AND of pnf_per_byte, registered in the same cycle. Both bits are sticky until reset.
- Stray data: local_rdata_valid in IDLE, WRITE or DONE, or with rx count already == NUM_WORDS, clears pnf (all byte bits) and sets test_status[7] (sticky). It does not increment rx.
- local_init_done dropping after leaving IDLE is ignored.
- test_status: [2:0] state (IDLE=0, WRITE=1, READ=2, WAIT_RD=3, DONE=4), [5:3] pass[2:0], [6]=0, [7] stray-data flag.
- Reset mid-operation: immediate return to reset values; outstanding read returns after reset deasserts hit the stray-data rule only if they arrive in IDLE.

Optional Feature:
DRIVER_ERR_INJECT_EN: when defined, the write in pass 0, idx 3 has wdata bit 0 inverted. The readback of that word must clear pnf_per_byte[0] and pnf, and test_complete still asserts normally. When undefined, data is always the exact pattern.

Test Plan:
- Defaults, ideal controller (local_ready=1, read latency 8 cycles): 4x(16 writes + 16 reads); test_complete=1, pnf=1, pnf_per_byte=16'hFFFF, test_status=8'h1C (state 4, pass 3).
- local_ready toggled pseudo-randomly: request, address and wdata stay stable while ready is low; no duplicate or skipped address; final pnf=1.
- Model corrupts byte 5 of readback for pass 1, idx 7: pnf_per_byte=16'hFFDF and pnf=0 (sticky), completion still reached.
- Extra rdata_valid pulse in WRITE of pass 2: pnf=0, test_status[7]=1, test flow unaffected.
- Assert reset in READ of pass 1, then release: outputs return to reset values, the test waits for init_done and then restarts at pass 0, idx 0 with address BASE_ADDR.
- With DRIVER_ERR_INJECT_EN defined: pass 0 idx 3 wdata[0] inverted vs pattern; final pnf_per_byte[0]=0, pnf=0, test_complete=1.

Source files
------------

// File: rtl/ddr3_int_traffic_driver.sv
// DDR3 example-design traffic driver: write/read/compare passes on the local
// interface, reporting pnf, pnf_per_byte, test_complete and test_status.
//
// Ports:
//   clk, reset (async, active-high), local_init_done
//   local_ready, local_write_req, local_read_req, local_burstbegin
//   local_address, local_size, local_be, local_wdata
//   local_rdata, local_rdata_valid
//   pnf, pnf_per_byte, test_complete, test_status
//
// Optional build macro: DRIVER_ERR_INJECT_EN
//   When defined, the pass-0 / idx-3 write has wdata bit 0 inverted.
//   When undefined, write data is always the exact pattern.

module ddr3_int_traffic_driver #(
  parameter int LOCAL_DATA_BITS = 128,
  parameter int ADDR_BITS       = 24,
  parameter int BASE_ADDR       = 0,
  parameter int NUM_WORDS       = 16,
  parameter int NUM_PASSES      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         local_init_done,
  input  logic                         local_ready,
  output logic                         local_write_req,
  output logic                         local_read_req,
  output logic                         local_burstbegin,
  output logic [ADDR_BITS-1:0]         local_address,
  output logic                         local_size,
  output logic [LOCAL_DATA_BITS/8-1:0] local_be,
  output logic [LOCAL_DATA_BITS-1:0]   local_wdata,
  input  logic [LOCAL_DATA_BITS-1:0]   local_rdata,
  input  logic                         local_rdata_valid,
  output logic                         pnf,
  output logic [LOCAL_DATA_BITS/8-1:0] pnf_per_byte,
  output logic                         test_complete,
  output logic [7:0]                   test_status
);

  localparam int NB = LOCAL_DATA_BITS / 8;
  localparam int NL = LOCAL_DATA_BITS / 32;

  // 17 bits holds NUM_WORDS itself (up to 2^16) for the rx count.
  localparam int IW = 17;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [IW-1:0] ALL_RX   = IW'(NUM_WORDS);
  localparam logic [7:0]    LAST_P   = 8'(NUM_PASSES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    r_state;
  logic [7:0]    r_pass;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_rx;
  logic          r_gap;
  logic [NB-1:0] r_pnf_pb;
  logic          r_pnf;
  logic          r_stray;

  logic                       w_wr;
  logic                       w_rd;
  logic                       w_acc;
  logic                       w_last;
  logic                       w_inj;
  logic                       w_rx_ok;
  logic                       w_cmp;
  logic                       w_stray;
  logic [LOCAL_DATA_BITS-1:0] w_wpat;
  logic [LOCAL_DATA_BITS-1:0] w_rpat;
  logic [NB-1:0]              w_bad;
  logic [NB-1:0]              w_pb_nxt;

  // Word = {pass, idx zero-extended to 24 bits}; odd 32-bit lanes inverted.
  function automatic logic [LOCAL_DATA_BITS-1:0] f_pat(
    input logic [7:0]    p,
    input logic [IW-1:0] i
  );
    logic [31:0]                w;
    logic [LOCAL_DATA_BITS-1:0] d;
    w = {p, 7'd0, i};
    d = '0;
    for (int k = 0; k < NL; k++) begin
      d[k*32 +: 32] = k[0] ? ~w : w;
    end
    return d;
  endfunction

  assign w_wr   = (r_state == S_WRITE);
  assign w_rd   = (r_state == S_READ) && !r_gap;
  assign w_acc  = (w_wr || w_rd) && local_ready;
  assign w_last = (r_idx == LAST_IDX);

`ifdef DRIVER_ERR_INJECT_EN
  assign w_inj = (r_pass == 8'd0) && (r_idx == IW'(3));
`else
  assign w_inj = 1'b0;
`endif

  assign w_wpat = f_pat(r_pass, r_idx);
  assign w_rpat = f_pat(r_pass, r_rx);

  // Returns are only legal while reads are outstanding for this pass.
  assign w_rx_ok = ((r_state == S_READ) || (r_state == S_WAIT))
                && (r_rx != ALL_RX);
  assign w_cmp   = local_rdata_valid && w_rx_ok;
  assign w_stray = local_rdata_valid && !w_rx_ok;

  always_comb begin
    w_bad = '0;
    for (int b = 0; b < NB; b++) begin
      w_bad[b] = |(local_rdata[b*8 +: 8] ^ w_rpat[b*8 +: 8]);
    end
  end

  always_comb begin
    w_pb_nxt = r_pnf_pb;
    if (w_stray) begin
      w_pb_nxt = '0;
    end else if (w_cmp) begin
      w_pb_nxt = r_pnf_pb & ~w_bad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pass   <= '0;
      r_idx    <= '0;
      r_rx     <= '0;
      r_gap    <= 1'b0;
      r_pnf_pb <= '1;
      r_pnf    <= 1'b1;
      r_stray  <= 1'b0;
    end else begin
      r_pnf_pb <= w_pb_nxt;
      r_pnf    <= &w_pb_nxt;
      if (w_stray) begin
        r_stray <= 1'b1;
      end
      if (w_cmp) begin
        r_rx <= r_rx + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (local_init_done) begin
            r_state <= S_WRITE;
            r_idx   <= '0;
            r_pass  <= '0;
            r_rx    <= '0;
          end
        end
        S_WRITE: begin
          if (w_acc) begin
            if (w_last) begin
              r_state <= S_READ;
              r_idx   <= '0;
              r_gap   <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_READ: begin
          if (r_gap) begin
            r_gap <= 1'b0;
          end else if (w_acc) begin
            if (w_last) begin
              r_state <= S_WAIT;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_rx == ALL_RX) begin
            if (r_pass == LAST_P) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WRITE;
              r_pass  <= r_pass + 1'b1;
              r_idx   <= '0;
              r_rx    <= '0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign local_write_req  = w_wr;
  assign local_read_req   = w_rd;
  assign local_burstbegin = w_wr || w_rd;
  assign local_address    = ADDR_BITS'(BASE_ADDR)
                          + ADDR_BITS'(r_idx);
  assign local_size       = 1'b1;
  assign local_be         = '1;
  assign local_wdata      = w_wpat
                          ^ {{(LOCAL_DATA_BITS-1){1'b0}}, w_inj};
  assign pnf              = r_pnf;
  assign pnf_per_byte     = r_pnf_pb;
  assign test_complete    = (r_state == S_DONE);
  assign test_status      = {r_stray, 1'b0, r_pass[2:0], r_state};

endmodule

// File: tb/tb_ddr3_int_traffic_driver.sv
// Bench for ddr3_int_traffic_driver: controller model with memory,
// request scoreboard and directed pass/fail scenarios.

module tb_ddr3_int_traffic_driver;

  localparam int DW = 128;
  localparam int AW = 24;
  localparam int NB = DW / 8;
  localparam int NW = 16;
  localparam int NP = 4;

`ifdef DRIVER_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  localparam logic [NB-1:0] PB_OK  = INJ ? 16'hFFFE : 16'hFFFF;
  localparam logic          PNF_OK = !INJ;
  localparam logic [NB-1:0] PB_COR = INJ ? 16'hFFDE : 16'hFFDF;

  logic          clk = 1'b0;
  logic          reset;
  logic          local_init_done;
  logic          local_ready;
  logic          local_write_req;
  logic          local_read_req;
  logic          local_burstbegin;
  logic [AW-1:0] local_address;
  logic          local_size;
  logic [NB-1:0] local_be;
  logic [DW-1:0] local_wdata;
  logic [DW-1:0] local_rdata;
  logic          local_rdata_valid;
  logic          pnf;
  logic [NB-1:0] pnf_per_byte;
  logic          test_complete;
  logic [7:0]    test_status;

  always #5 clk = ~clk;

  ddr3_int_traffic_driver dut (
    .clk               (clk),
    .reset             (reset),
    .local_init_done   (local_init_done),
    .local_ready       (local_ready),
    .local_write_req   (local_write_req),
    .local_read_req    (local_read_req),
    .local_burstbegin  (local_burstbegin),
    .local_address     (local_address),
    .local_size        (local_size),
    .local_be          (local_be),
    .local_wdata       (local_wdata),
    .local_rdata       (local_rdata),
    .local_rdata_valid (local_rdata_valid),
    .pnf               (pnf),
    .pnf_per_byte      (pnf_per_byte),
    .test_complete     (test_complete),
    .test_status       (test_status)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int p, input int i);
    logic [31:0] w;
    w = {p[7:0], i[23:0]};
    return {~w, w, ~w, w};
  endfunction

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ret_t;

  req_t          exp_q[$];
  ret_t          ret_q[$];
  logic [DW-1:0] mem[int];

  int cyc        = 0;
  int rd_cnt     = 0;
  int stray_req  = 0;
  int stray_done = 0;
  bit ready_rand = 1'b0;
  bit corrupt_en = 1'b0;

  // Controller model: accepts at negedge view, returns reads ~8 cycles later.
  initial begin : model
    req_t          e;
    ret_t          r;
    bit            pend;
    bit            h_wr;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    logic [DW-1:0] d;
    local_ready       = 1'b1;
    local_rdata_valid = 1'b0;
    local_rdata       = '0;
    pend              = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("hold_req",
              h_wr ? local_write_req : local_read_req, 1);
          chk("hold_addr", local_address, h_addr);
          if (h_wr) chk("hold_wdata", local_wdata, h_data);
          pend = 1'b0;
        end
        if (local_write_req || local_read_req) begin
          if (!local_ready) begin
            pend   = 1'b1;
            h_wr   = local_write_req;
            h_addr = local_address;
            h_data = local_wdata;
          end else begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("req_kind", {local_write_req, local_read_req},
                  {e.wr, !e.wr});
              chk("burstbegin", local_burstbegin, 1);
              chk("req_addr", local_address, e.addr);
              if (e.wr) begin
                chk("wdata", local_wdata, e.data);
                mem[int'(local_address)] = local_wdata;
              end else begin
                d = '0;
                if (mem.exists(int'(local_address)) != 0)
                  d = mem[int'(local_address)];
                if (corrupt_en && rd_cnt == NW + 7)
                  d[47:40] = ~d[47:40];
                r.due  = cyc + 8;
                r.data = d;
                ret_q.push_back(r);
                rd_cnt++;
              end
            end
          end
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      local_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (reset) begin
        local_rdata_valid = 1'b0;
        ret_q.delete();
        exp_q.delete();
        rd_cnt = 0;
        for (int p = 0; p < NP; p++) begin
          for (int i = 0; i < NW; i++) begin
            e.wr   = 1'b1;
            e.addr = AW'(i);
            e.data = pat(p, i);
            if (INJ && p == 0 && i == 3) e.data[0] = ~e.data[0];
            exp_q.push_back(e);
          end
          for (int i = 0; i < NW; i++) begin
            e.wr   = 1'b0;
            e.addr = AW'(i);
            e.data = '0;
            exp_q.push_back(e);
          end
        end
      end else if (ret_q.size() != 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        local_rdata_valid = 1'b1;
        local_rdata       = r.data;
      end else if (stray_req != stray_done) begin
        stray_done++;
        local_rdata_valid = 1'b1;
        local_rdata       = '1;
      end else begin
        local_rdata_valid = 1'b0;
      end
    end
  end

  task automatic start_run();
    @(posedge clk);
    #2;
    reset           = 1'b1;
    local_init_done = 1'b0;
    @(negedge clk);
    chk("rst_in_status", test_status, 8'h00);
    chk("rst_in_req", {local_write_req, local_read_req}, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_status", test_status, 8'h00);
    chk("rst_burst", local_burstbegin, 0);
    chk("rst_addr", local_address, 0);
    chk("rst_pnf", pnf, 1);
    chk("rst_pb", pnf_per_byte, 16'hFFFF);
    chk("rst_complete", test_complete, 0);
    chk("rst_size", local_size, 1);
    chk("rst_be", local_be, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("idle_status", test_status, 8'h00);
    chk("idle_req", local_write_req | local_read_req, 0);
    #2;
    local_init_done = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (test_complete !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("complete", test_complete, 1);
  endtask

  task automatic wait_status(input logic [7:0] s);
    int n = 0;
    while (test_status !== s && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_status", test_status, s);
  endtask

  task automatic final_chk(input logic [NB-1:0] pb,
                           input logic pf,
                           input logic [7:0] st);
    repeat (2) @(negedge clk);
    chk("end_pb", pnf_per_byte, pb);
    chk("end_pnf", pnf, pf);
    chk("end_status", test_status, st);
    chk("end_complete", test_complete, 1);
    chk("end_sb_empty", exp_q.size(), 0);
    chk("end_req", {local_write_req, local_read_req}, 2'b00);
  endtask

  initial begin : main
    reset           = 1'b1;
    local_init_done = 1'b0;
    repeat (2) @(posedge clk);

    start_run();
    wait_done();
    final_chk(PB_OK, PNF_OK, 8'h1C);

    ready_rand = 1'b1;
    start_run();
    wait_status(8'h02);
    local_init_done = 1'b0;
    wait_done();
    final_chk(PB_OK, PNF_OK, 8'h1C);
    ready_rand = 1'b0;

    corrupt_en = 1'b1;
    start_run();
    wait_done();
    final_chk(PB_COR, 1'b0, 8'h1C);
    corrupt_en = 1'b0;

    start_run();
    wait_status(8'h11);
    stray_req++;
    wait_done();
    final_chk('0, 1'b0, 8'h9C);

    start_run();
    wait_status(8'h0A);
    start_run();
    wait_done();
    final_chk(PB_OK, PNF_OK, 8'h1C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
